// File: rtl/keypad_pkg.sv
// Shared types, sizes and lookup helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic {
        SCAN = 1'b0,
        HELD = 1'b1
    } state_t;

    // Key legend indexed [row][col]; '*' maps to E and '#' maps to F.
    localparam logic [0:ROWS-1][0:COLS-1][CODE_W-1:0] KEYMAP = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Hex code of the key at a given row/column crossing.
    function automatic logic [CODE_W-1:0] keymap(input logic [IDX_W-1:0] row,
                                                 input logic [IDX_W-1:0] col);
        return KEYMAP[row][col];
    endfunction

    // Lowest-index row that is pulled low; only meaningful when some row is low.
    function automatic logic [IDX_W-1:0] low_row(input logic [ROWS-1:0] rows);
        logic [IDX_W-1:0] r;
        r = IDX_W'(3);
        if (!rows[2]) r = IDX_W'(2);
        if (!rows[1]) r = IDX_W'(1);
        if (!rows[0]) r = IDX_W'(0);
        return r;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: one-cold column drive, settle dwell per column,
// lowest-row priority, single valid strobe per press and a held level.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 600000,
    parameter int unsigned CNT_W         = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [ROWS-1:0]     rows_clean,
    output logic [COLS-1:0]     cols_n,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t              r_state,     w_state;
    logic [IDX_W-1:0]    r_col,       w_col;
    logic [IDX_W-1:0]    r_row,       w_row;
    logic [CNT_W-1:0]    r_cnt,       w_cnt;
    logic [COLS-1:0]     r_cols_n,    w_cols_n;
    logic [CODE_W-1:0]   r_key_code,  w_key_code;
    logic                r_key_valid, w_key_valid;
    logic                r_key_held,  w_key_held;
    logic                w_any_low;

    assign w_any_low = ~&rows_clean;

    // Next-state, counter and output decode.
    always_comb begin
        w_state     = r_state;
        w_col       = r_col;
        w_row       = r_row;
        w_cnt       = r_cnt;
        w_key_code  = r_key_code;
        w_key_valid = 1'b0;
        w_key_held  = r_key_held;
        w_cols_n    = r_cols_n;

        case (r_state)
            SCAN: begin
                if (!scan_en) begin
                    w_cnt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt = '0;
                    if (w_any_low) begin
                        w_row       = low_row(rows_clean);
                        w_key_code  = keymap(w_row, r_col);
                        w_key_valid = 1'b1;
                        w_key_held  = 1'b1;
                        w_state     = HELD;
                    end else begin
                        w_col = r_col + IDX_W'(1);
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (rows_clean[r_row]) begin
                    w_key_held = 1'b0;
                    w_col      = r_col + IDX_W'(1);
                    w_cnt      = '0;
                    w_state    = SCAN;
                end
            end
            default: begin
                w_state = SCAN;
            end
        endcase

        // Column drive follows the column that will be active next cycle.
        if ((w_state == SCAN) && !scan_en) begin
            w_cols_n = '1;
        end else begin
            w_cols_n = ~(COLS'(1) << w_col);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SCAN;
            r_col       <= '0;
            r_row       <= '0;
            r_cnt       <= '0;
            r_cols_n    <= 4'b1110;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_col       <= w_col;
            r_row       <= w_row;
            r_cnt       <= w_cnt;
            r_cols_n    <= w_cols_n;
            r_key_code  <= w_key_code;
            r_key_valid <= w_key_valid;
            r_key_held  <= w_key_held;
        end
    end

    assign cols_n    = r_cols_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a small keypad switch model.
module tb_keypad_scanner;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic [3:0]  rows_clean;
    logic [3:0]  cols_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;        // bit row*4+col = switch closed
    logic [3:0]  exp_q[$];
    int          vectors;
    int          miscompares;
    logic        prev_valid;

    keypad_scanner #(
        .SETTLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_en    (scan_en),
        .rows_clean (rows_clean),
        .cols_n     (cols_n),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a row reads low when a closed switch meets a driven column.
    always_comb begin
        rows_clean = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols_n[c]) rows_clean[r] = 1'b0;
            end
        end
    end

    // Monitor: every strobe pops the scoreboard; back-to-back strobes are errors.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            vectors++;
            if (prev_valid) begin
                miscompares++;
                $display("FAIL strobe_width key_valid high two cycles, required one");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL strobe_unexpected key_code=%h, required no strobe", key_code);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    miscompares++;
                    $display("FAIL key_code got=%h required=%h", key_code, e);
                end
            end
        end
        prev_valid = (key_valid === 1'b1);
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    task automatic wait_valid(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout got=no strobe required=strobe", name);
        end
    endtask

    task automatic wait_release(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (key_held === 1'b0) seen = 1'b1;
        end
        check(name, {3'b0, key_held}, 4'h0);
    endtask

    task automatic press_key(input string name, input logic [15:0] p, input logic [3:0] e);
        exp_q.push_back(e);
        pressed = p;
        wait_valid(name);
        check({name, "_held"}, {3'b0, key_held}, 4'h1);
        repeat (3) @(negedge clk);
        pressed = '0;
        wait_release({name, "_rel"});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        prev_valid  = 1'b0;
        pressed     = '0;
        rst         = 1'b1;
        scan_en     = 1'b0;

        // 1. reset state
        repeat (2) @(negedge clk);
        check("rst_cols_n",    cols_n,             4'b1110);
        check("rst_key_code",  key_code,           4'h0);
        check("rst_key_valid", {3'b0, key_valid},  4'h0);
        check("rst_key_held",  {3'b0, key_held},   4'h0);

        // 2. idle scan: each column driven for four cycles
        rst     = 1'b0;
        scan_en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            logic [3:0] e;
            @(negedge clk);
            e = ~(4'b0001 << ((k / 4) % 4));
            check("scan_step", cols_n, e);
        end

        // 3. row1 on column 2 -> 6
        exp_q.push_back(4'h6);
        pressed = 16'h0040;
        wait_valid("key6");
        check("key6_cols_n", cols_n, 4'b1011);
        check("key6_held",   {3'b0, key_held}, 4'h1);
        @(negedge clk);
        check("key6_strobe_drop", {3'b0, key_valid}, 4'h0);

        // 4. long hold, then release
        repeat (100) @(negedge clk);
        check("hold_held",   {3'b0, key_held}, 4'h1);
        check("hold_cols_n", cols_n, 4'b1011);
        pressed = '0;
        @(negedge clk);
        check("rel_held",   {3'b0, key_held}, 4'h0);
        check("rel_cols_n", cols_n, 4'b0111);

        // 5. row priority and '*' / '#' mapping
        press_key("rows03_col1", 16'h2002, 4'h2);
        press_key("row3_col0",   16'h1000, 4'hE);
        press_key("row3_col2",   16'h4000, 4'hF);
        // Column 3 is scanned next, so C beats 2 in column 1.
        press_key("two_cols",    16'h0802, 4'hC);

        // 6. reset while held, then scanning disabled
        exp_q.push_back(4'h5);
        pressed = 16'h0020;
        wait_valid("key5");
        rst = 1'b1;
        @(negedge clk);
        check("rsth_cols_n", cols_n,            4'b1110);
        check("rsth_held",   {3'b0, key_held},  4'h0);
        check("rsth_valid",  {3'b0, key_valid}, 4'h0);
        scan_en = 1'b0;
        rst     = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("dis_cols_n", cols_n, 4'b1111);
        end
        pressed = '0;
        scan_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic [3:0] e;
            @(negedge clk);
            e = ~(4'b0001 << ((k / 4) % 4));
            check("resume_step", cols_n, e);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 4'(exp_q.size()), 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
